// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writebacks, registered write.
// Define REGFILE_CLEAR_EN to zero-fill every register after reset before traffic is accepted.
module regfile_wr_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              busy
);

  typedef enum logic {GRANT_A, GRANT_M} grant_t;

  grant_t lastGrant;
  logic   inRun;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] cnt;

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == CLEAR && cnt == '1) stateNext = RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset)              cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + ADDR_W'(1);
  end

  assign inRun = (state == RUN);
`else
  assign inRun = 1'b1;
`endif

  // Grants are gated by reset so nothing is accepted while the block is being reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    a_ready = 1'b0;
    m_ready = 1'b0;
    busy    = reset & ~inRun;
    if (reset && inRun) begin
      a_ready = a_valid & (~m_valid | (lastGrant == GRANT_M));
      m_ready = m_valid & ~a_ready;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWrite  <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      lastGrant <= GRANT_M;
    end
`ifdef REGFILE_CLEAR_EN
    else if (!inRun) begin
      RegWrite <= 1'b1;
      wrAddr   <= cnt;
      wrData   <= '0;
    end
`endif
    else if (a_ready) begin
      RegWrite  <= 1'b1;
      wrAddr    <= a_addr;
      wrData    <= a_data;
      lastGrant <= GRANT_A;
    end
    else if (m_ready) begin
      RegWrite  <= 1'b1;
      wrAddr    <= m_addr;
      wrData    <= m_data;
      lastGrant <= GRANT_M;
    end
    else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter; follows REGFILE_CLEAR_EN to pick the sweep or no-sweep scenarios.
module tb_regfile_wr_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef struct {
    bit                v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, m_valid;
  logic [ADDR_W-1:0] a_addr, m_addr;
  logic [DATA_W-1:0] a_data, m_data;
  logic              a_ready, m_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              busy;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .RegWrite(RegWrite), .wrAddr(wrAddr), .wrData(wrData), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and releases it; the next edge is the first one sampling reset high.
  task automatic apply_reset();
    reset   = 1'b0;
    a_valid = 1'b0;
    m_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic go_run();
    apply_reset();
`ifdef REGFILE_CLEAR_EN
    repeat (NREG) tick();
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    m_valid = 1'b1; m_addr = 5'd6; m_data = 32'h5678;
    tick();
    tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got %b exp 0", a_ready); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got %b exp 0", m_ready); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite); end
    checks++; if (wrAddr !== 5'd0) begin errors++; $display("FAIL reset_wraddr got %0d exp 0", wrAddr); end
    checks++; if (wrData !== 32'd0) begin errors++; $display("FAIL reset_wrdata got %0h exp 0", wrData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    // Reset arriving while a request is pending: the request must not be written.
    go_run();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hDEAD;
    reset = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL midtraffic_a_ready got %b exp 0", a_ready); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL midtraffic_regwrite got %b exp 0", RegWrite); end
    a_valid = 1'b0; m_valid = 1'b0;
  endtask

`ifdef REGFILE_CLEAR_EN
  task automatic test_sweep();
    apply_reset();
    for (int k = 0; k < NREG; k++) begin
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy[%0d] got %b exp 1", k, busy); end
      tick();
      checks++;
      if (RegWrite !== 1'b1 || wrAddr !== k[ADDR_W-1:0] || wrData !== 32'd0) begin
        errors++;
        $display("FAIL sweep_write[%0d] got we=%b addr=%0d data=%0h exp we=1 addr=%0d data=0", k, RegWrite, wrAddr, wrData, k);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_done_busy got %b exp 0", busy); end
  endtask

  task automatic test_clear_with_valids();
    apply_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h44;
    for (int k = 0; k < NREG; k++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
        errors++; $display("FAIL clear_ready[%0d] got a=%b m=%b exp a=0 m=0", k, a_ready, m_ready);
      end
      tick();
    end
    #1;
    checks++; if (a_ready !== 1'b1 || m_ready !== 1'b0) begin errors++; $display("FAIL clear_first_grant got a=%b m=%b exp a=1 m=0", a_ready, m_ready); end
    tick();
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd3 || wrData !== 32'h33) begin errors++; $display("FAIL clear_first_write got we=%b addr=%0d data=%0h exp we=1 addr=3 data=33", RegWrite, wrAddr, wrData); end
    #1;
    checks++; if (a_ready !== 1'b0 || m_ready !== 1'b1) begin errors++; $display("FAIL clear_second_grant got a=%b m=%b exp a=0 m=1", a_ready, m_ready); end
    tick();
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd4 || wrData !== 32'h44) begin errors++; $display("FAIL clear_second_write got we=%b addr=%0d data=%0h exp we=1 addr=4 data=44", RegWrite, wrAddr, wrData); end
    a_valid = 1'b0; m_valid = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    apply_reset();
    repeat (17) tick();
    checks++; if (wrAddr !== 5'd16) begin errors++; $display("FAIL midsweep_pre_addr got %0d exp 16", wrAddr); end
    reset = 1'b0;
    tick();
    checks++;
    if (RegWrite !== 1'b0 || wrAddr !== 5'd0 || wrData !== 32'd0 || busy !== 1'b0 || a_ready !== 1'b0 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset got we=%b addr=%0d data=%0h busy=%b exp all 0", RegWrite, wrAddr, wrData, busy);
    end
    reset = 1'b1;
    tick();
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd0) begin errors++; $display("FAIL midsweep_restart got we=%b addr=%0d exp we=1 addr=0", RegWrite, wrAddr); end
    repeat (NREG - 1) tick();
    checks++; if (wrAddr !== 5'd31 || busy !== 1'b0) begin errors++; $display("FAIL midsweep_end got addr=%0d busy=%b exp addr=31 busy=0", wrAddr, busy); end
  endtask
`else
  task automatic test_no_clear();
    apply_reset();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL noclear_a_ready got %b exp 1", a_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noclear_busy got %b exp 0", busy); end
    tick();
    a_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd7 || wrData !== 32'h77) begin errors++; $display("FAIL noclear_write got we=%b addr=%0d data=%0h exp we=1 addr=7 data=77", RegWrite, wrAddr, wrData); end
  endtask
`endif

  task automatic test_single();
    go_run();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h15;
    #1;
    checks++; if (a_ready !== 1'b1 || m_ready !== 1'b0) begin errors++; $display("FAIL single_ready got a=%b m=%b exp a=1 m=0", a_ready, m_ready); end
    tick();
    a_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd10 || wrData !== 32'h15) begin errors++; $display("FAIL single_write got we=%b addr=%0d data=%0h exp we=1 addr=10 data=15", RegWrite, wrAddr, wrData); end
    tick();
    checks++; if (RegWrite !== 1'b0 || wrAddr !== 5'd10 || wrData !== 32'h15) begin errors++; $display("FAIL single_idle_hold got we=%b addr=%0d data=%0h exp we=0 addr=10 data=15", RegWrite, wrAddr, wrData); end
  endtask

  task automatic test_round_robin();
    bit expA;
    go_run();
    a_valid = 1'b1; a_addr = 5'd15; a_data = 32'hAAAA;
    m_valid = 1'b1; m_addr = 5'd10; m_data = 32'hBBBB;
    for (int i = 0; i < 4; i++) begin
      expA = (i % 2 == 0);
      #1;
      checks++; if (a_ready !== expA || m_ready !== !expA) begin errors++; $display("FAIL rr_grant[%0d] got a=%b m=%b exp a=%b", i, a_ready, m_ready, expA); end
      tick();
      checks++; if (RegWrite !== 1'b1 || wrAddr !== (expA ? 5'd15 : 5'd10)) begin errors++; $display("FAIL rr_write[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, RegWrite, wrAddr, expA ? 15 : 10); end
    end
    a_valid = 1'b0; m_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    go_run();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h111;
    m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h222;
    tick();
    a_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd0 || wrData !== 32'h111) begin errors++; $display("FAIL b2b_first got we=%b addr=%0d data=%0h exp we=1 addr=0 data=111", RegWrite, wrAddr, wrData); end
    tick();
    m_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd0 || wrData !== 32'h222) begin errors++; $display("FAIL b2b_second got we=%b addr=%0d data=%0h exp we=1 addr=0 data=222", RegWrite, wrAddr, wrData); end
  endtask

  // Randomized traffic against a requester-level model: each side holds one pending request until granted.
  task automatic test_random();
    req_t              aq, mq;
    bit                lastWasA, grantA, grantM, expWe;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;
    go_run();
    aq.v = 0; mq.v = 0; lastWasA = 0; expData = '0;
`ifdef REGFILE_CLEAR_EN
    expAddr = ADDR_W'(NREG - 1);
`else
    expAddr = '0;
`endif
    for (int c = 0; c < 400; c++) begin
      if (!aq.v && $urandom_range(0, 2) != 0) begin aq.v = 1; aq.addr = ADDR_W'($urandom); aq.data = $urandom; end
      if (!mq.v && $urandom_range(0, 2) != 0) begin mq.v = 1; mq.addr = ADDR_W'($urandom); mq.data = $urandom; end
      a_valid = aq.v; a_addr = aq.addr; a_data = aq.data;
      m_valid = mq.v; m_addr = mq.addr; m_data = mq.data;
      grantA = aq.v && (!mq.v || !lastWasA);
      grantM = mq.v && !grantA;
      #1;
      checks++; if (a_ready !== grantA || m_ready !== grantM) begin errors++; $display("FAIL rand_ready[%0d] got a=%b m=%b exp a=%b m=%b", c, a_ready, m_ready, grantA, grantM); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy[%0d] got %b exp 0", c, busy); end
      tick();
      expWe = grantA || grantM;
      if (grantA) begin expAddr = aq.addr; expData = aq.data; lastWasA = 1; aq.v = 0; end
      if (grantM) begin expAddr = mq.addr; expData = mq.data; lastWasA = 0; mq.v = 0; end
      checks++;
      if (RegWrite !== expWe || wrAddr !== expAddr || wrData !== expData) begin
        errors++;
        $display("FAIL rand_write[%0d] got we=%b addr=%0d data=%0h exp we=%b addr=%0d data=%0h", c, RegWrite, wrAddr, wrData, expWe, expAddr, expData);
      end
    end
    a_valid = 1'b0; m_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    test_reset();
`ifdef REGFILE_CLEAR_EN
    test_sweep();
    test_clear_with_valids();
    test_reset_mid_sweep();
`else
    test_no_clear();
`endif
    test_single();
    test_round_robin();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
